// File: rtl/fp_add_sub_seq.sv
// rtl/fp_add_sub_seq.sv - iterative binary32 add/subtract core with valid/ready handshakes
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   in_valid/in_ready      : operand handshake (a, b, operation_select: 0=a+b, 1=a-b)
//   out_valid/out_ready    : result handshake (result, flags={invalid,overflow,underflow,inexact})
module fp_add_sub_seq #(
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23,
  localparam int WIDTH    = 1 + EXP_BITS + MANT_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             operation_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  // Significand with hidden bit, plus carry bit on top and guard/round/sticky below.
  localparam int SIG = MANT_BITS + 1;
  localparam int M   = SIG + 4;
  localparam int EW  = EXP_BITS + 2;
  localparam logic [EXP_BITS-1:0] EMAX = '1;
  // Beyond this distance every small-operand bit lands in sticky.
  localparam logic [EXP_BITS-1:0] ALIGN_MAX = EXP_BITS'(SIG + 2);
  localparam logic [WIDTH-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MANT_BITS-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic                op_q, op_d;
  logic [M-1:0]        big_q, big_d, small_q, small_d;
  logic [EW-1:0]       exp_q, exp_d;
  logic                sign_q, sign_d;
  logic                sub_q, sub_d;
  logic [EXP_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [3:0]          flags_q, flags_d;

  // Field decode of the latched operands; b carries its effective sign.
  logic                 a_s, b_s;
  logic [EXP_BITS-1:0]  a_e, b_e, big_e, small_e, diff;
  logic [MANT_BITS-1:0] a_m, b_m, big_m, small_m;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge_b;

  assign a_s = a_q[WIDTH-1];
  assign b_s = b_q[WIDTH-1] ^ op_q;
  assign a_e = a_q[WIDTH-2:MANT_BITS];
  assign b_e = b_q[WIDTH-2:MANT_BITS];
  assign a_m = a_q[MANT_BITS-1:0];
  assign b_m = b_q[MANT_BITS-1:0];

  // Exponent 0 covers both zero and subnormal: subnormals flush to zero.
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);
  assign a_inf  = (a_e == EMAX) && (a_m == '0);
  assign b_inf  = (b_e == EMAX) && (b_m == '0);
  assign a_nan  = (a_e == EMAX) && (a_m != '0);
  assign b_nan  = (b_e == EMAX) && (b_m != '0);

  // Comparing exponent:mantissa as one unsigned field orders magnitudes.
  assign a_ge_b  = (a_q[WIDTH-2:0] >= b_q[WIDTH-2:0]);
  assign big_e   = a_ge_b ? a_e : b_e;
  assign small_e = a_ge_b ? b_e : a_e;
  assign big_m   = a_ge_b ? a_m : b_m;
  assign small_m = a_ge_b ? b_m : a_m;
  assign diff    = big_e - small_e;

  // Rounding datapath, used only in ROUND.
  logic [SIG-1:0] rnd_mant;
  logic           rnd_g, rnd_r, rnd_s, rnd_up;
  logic [SIG:0]   rnd_sum;
  logic [EW-1:0]  rnd_exp;

  assign rnd_mant = big_q[M-2:3];
  assign rnd_g    = big_q[2];
  assign rnd_r    = big_q[1];
  assign rnd_s    = big_q[0];
  assign rnd_up   = rnd_g & (rnd_r | rnd_s | rnd_mant[0]);
  assign rnd_sum  = {1'b0, rnd_mant} + {{SIG{1'b0}}, rnd_up};
  assign rnd_exp  = exp_q + EW'(rnd_sum[SIG]);

  logic [M-1:0] addsub;
  assign addsub = sub_q ? (big_q - small_q) : (big_q + small_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      big_q    <= '0;
      small_q  <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      big_q    <= big_d;
      small_q  <= small_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      sub_q    <= sub_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    big_d    = big_q;
    small_d  = small_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    sub_d    = sub_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = operation_select;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        flags_d = 4'b0000;
        state_d = S_DONE;
        if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
          result_d = QNAN;
          flags_d  = 4'b1000;
        end else if (a_inf) begin
          result_d = a_q;
        end else if (b_inf) begin
          result_d = {b_s, b_q[WIDTH-2:0]};
        end else if (a_zero && b_zero) begin
          result_d = {a_s & b_s, {(WIDTH-1){1'b0}}};
        end else if (a_zero) begin
          result_d = {b_s, b_q[WIDTH-2:0]};
        end else if (b_zero) begin
          result_d = a_q;
        end else begin
          big_d   = {2'b01, big_m, 3'b000};
          small_d = {2'b01, small_m, 3'b000};
          exp_d   = EW'(big_e);
          sign_d  = a_ge_b ? a_s : b_s;
          sub_d   = a_s ^ b_s;
          cnt_d   = diff;
          state_d = (diff == '0) ? S_ADD : S_ALIGN;
        end
      end

      S_ALIGN: begin
        if (cnt_q > ALIGN_MAX) begin
          small_d = {{(M-1){1'b0}}, 1'b1};
          state_d = S_ADD;
        end else begin
          // Sticky-preserving shift: the bit leaving position 0 folds into it.
          small_d = {1'b0, small_q[M-1:2], small_q[1] | small_q[0]};
          cnt_d   = cnt_q - EXP_BITS'(1);
          if (cnt_q == EXP_BITS'(1)) state_d = S_ADD;
        end
      end

      S_ADD: begin
        if (addsub == '0) begin
          result_d = '0;
          flags_d  = 4'b0000;
          state_d  = S_DONE;
        end else begin
          big_d   = addsub;
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (big_q[M-1]) begin
          big_d = {1'b0, big_q[M-1:2], big_q[1] | big_q[0]};
          exp_d = exp_q + EW'(1);
        end else if (!big_q[M-2]) begin
          if (exp_q == EW'(1)) begin
            result_d = {sign_q, {(WIDTH-1){1'b0}}};
            flags_d  = 4'b0011;
            state_d  = S_DONE;
          end else begin
            big_d = {big_q[M-2:0], 1'b0};
            exp_d = exp_q - EW'(1);
          end
        end else begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        state_d = S_DONE;
        if (rnd_exp >= {2'b00, EMAX}) begin
          result_d = {sign_q, EMAX, {MANT_BITS{1'b0}}};
          flags_d  = 4'b0101;
        end else begin
          // On mantissa carry-out the low bits are all zero, so no re-slice is needed.
          result_d = {sign_q, rnd_exp[EXP_BITS-1:0], rnd_sum[MANT_BITS-1:0]};
          flags_d  = {3'b000, rnd_g | rnd_r | rnd_s};
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: doc/fp_add_sub_seq.md
Name: fp_add_sub_seq

Overview:
- Multi-cycle IEEE-754 binary32 add/subtract core. It is the responder side of the operand/result interface that the random-stimulus bench drives (a, b, operation_select in; result out).
- Uses a valid/ready handshake on both sides so benches and future pipelines can apply backpressure.
- Iterative alignment and normalization, one bit per cycle, keep area small.
- Sits beside add_sub_main as its sequential, handshaked counterpart.

Parameters:
- EXP_BITS, 8, exponent field width.
- MANT_BITS, 23, stored mantissa field width.
- WIDTH, 1+EXP_BITS+MANT_BITS (32), operand/result width. Derived; do not override independently.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
- in_valid, input, 1, operands present.
- in_ready, output, 1, core can accept operands.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- operation_select, input, 1, 0 = a+b, 1 = a-b.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- result, output, WIDTH, packed binary32 result.
- flags, output, 4, {invalid, overflow, underflow, inexact}; valid with out_valid.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; in_ready=1; out_valid=0; result=0; flags=0.
  - Reset mid-operation aborts and discards the operation.
- States: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - Capture on in_valid&&in_ready: latch a, b, operation_select; deassert in_ready next cycle.
  - in_ready stays 0 until return to IDLE. No operand is accepted while busy.
- UNPACK (1 cycle):
  - Effective sign of b = b[31]^operation_select.
  - Subnormal inputs are flushed to signed zero (FTZ).
  - Special cases skip straight to DONE:
    - Any NaN -> 0x7FC00000, invalid=1.
    - Inf-Inf (effective) -> 0x7FC00000, invalid=1.
    - Inf op finite -> that Inf.
    - Both zero -> +0, except (-0)+(-0) -> -0.
    - One zero -> the other operand, with its sign adjusted if it is b.
  - Otherwise swap so the operand with the larger exponent (then larger mantissa) is the big operand.
  - Form 24-bit significands with the hidden 1, plus 3 bits guard/round/sticky.
- ALIGN:
  - diff = exp_big - exp_small.
  - If diff > 26: the small significand collapses into sticky in 1 cycle.
  - Else shift the small significand right 1 bit per cycle, diff cycles; each bit shifted out ORs into sticky.
  - diff=0 takes 0 cycles in ALIGN.
- ADD (1 cycle):
  - Same effective signs: add with a 25-bit result (carry kept).
  - Otherwise subtract small from big. Magnitude is non-negative by construction; the sign is that of the big operand.
  - Zero difference -> +0 and DONE.
- NORM:
  - On carry: shift right 1 (sticky accumulates), exp+1, 1 cycle.
  - Else shift left 1 per cycle while the hidden bit is 0, exp-1 each cycle.
  - If exp reaches 0 while shifting: flush to signed zero, underflow=1, inexact=1, go to DONE.
- ROUND (1 cycle):
  - Round-to-nearest-even using guard/round/sticky. inexact = G|R|S.
  - Mantissa carry-out renormalizes, exp+1.
  - exp >= 255 -> signed Inf, overflow=1, inexact=1.
- DONE:
  - out_valid=1, with result/flags stable while out_valid && !out_ready.
  - On out_ready: out_valid=0 next cycle, go to IDLE.
  - out_ready may be held high before DONE.
- Latency, capture to out_valid:
  - Normal path: 5 + align_cycles + norm_cycles.
  - Special cases: 2 cycles.
- Throughput: one operation in flight at a time.

Test Plan:
- Reset held 3 cycles, in_valid=1 throughout -> in_ready=1, out_valid=0, result=0. Nothing captured until rst_n=1.
- a=0x3F800000, b=0x3F800000, op=0 -> result=0x40000000, flags=0, latency 6.
- a=0x3F800000, b=0x33800000, op=1 -> result=0x3F7FFFFF, flags=0. ALIGN takes 24 cycles, NORM shifts 1. Same operands with op=0 (tie) -> 0x3F800000, inexact=1.
- Special cases:
  - a=0x3FC00000, b=0x3FC00000, op=1 -> 0x00000000.
  - a=0x7F800000, b=0x7F800000, op=1 -> 0x7FC00000, invalid=1.
  - a=0x7F7FFFFF, b=0x7F7FFFFF, op=0 -> 0x7F800000, overflow=1, inexact=1.
- Backpressure: out_ready=0 for 10 cycles at DONE -> result/flags stable, in_ready=0. New operands offered then are not captured until after the out_ready handshake.
- Reset asserted mid-ALIGN -> next cycle IDLE, in_ready=1, out_valid=0. The following operation (2.0+2.0 -> 0x40800000) completes correctly.
